// File: rtl/cmd_slave_regbank.sv
// cmd_slave_regbank: command-bus slave with a bank of RW control registers,
// a live STATUS word, a write-1-to-clear STICKY word and a constant ID word.
// Every access is acked a fixed ACK_DELAY_CLKS clocks after its select.
// Optional feature macro: CMD_SLAVE_ERRCNT_EN adds a 16-bit saturating
// counter of unmapped accesses at word index NUM_RW_REGS+3.
module cmd_slave_regbank #(
    parameter int          CMD_ADDR_BITS  = 24,
    parameter int          NUM_RW_REGS    = 8,
    parameter int          ACK_DELAY_CLKS = 1,
    parameter logic [31:0] BLOCK_ID       = 32'h0000_0000
) (
    input  logic                      i_sysclk,
    input  logic                      i_arst,
    input  logic                      i_cmd_sel,
    input  logic                      i_cmd_rd_wr_n,
    input  logic [CMD_ADDR_BITS-1:0]  i_cmd_byte_addr,
    input  logic [31:0]               i_cmd_wdata,
    output logic                      o_cmd_ack,
    output logic [31:0]               o_cmd_rdata,
    output logic [NUM_RW_REGS*32-1:0] o_ctrl_regs,
    input  logic [31:0]               i_status,
    input  logic [31:0]               i_event
);

    localparam int              IDX_W      = CMD_ADDR_BITS - 2;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_RW_REGS);
    localparam logic [IDX_W-1:0] STICKY_IDX = IDX_W'(NUM_RW_REGS + 1);
    localparam logic [IDX_W-1:0] ID_IDX     = IDX_W'(NUM_RW_REGS + 2);
    localparam logic [4:0]       LAST_CNT   = 5'(ACK_DELAY_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_q;
    logic [4:0]       cnt_q;
    logic             rd_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic             ack_q;
    logic [31:0]      rdata_q;
    logic [31:0]      regs_q [NUM_RW_REGS];
    logic [31:0]      sticky_q;
    logic [31:0]      sticky_d;

    logic                   fire_s;
    logic                   acc_rd_s;
    logic [IDX_W-1:0]       acc_idx_s;
    logic [31:0]            acc_wdata_s;
    logic                   wr_en_s;
    logic [NUM_RW_REGS-1:0] rw_hit_s;
    logic [31:0]            rw_data_s;
    logic [31:0]            rd_val_s;
    logic                   mapped_s;
    logic [31:0]            sticky_clr_s;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic unused_addr_s;
    assign unused_addr_s = ^i_cmd_byte_addr[1:0];

`ifdef CMD_SLAVE_ERRCNT_EN
    localparam logic [IDX_W-1:0] ERRCNT_IDX = IDX_W'(NUM_RW_REGS + 3);
    logic [15:0] errcnt_q;
`endif

    // Pick the access being completed: with a one-clock delay it completes on
    // the sampling edge itself, so the live inputs are used instead of the latch.
    always_comb begin
        if (ACK_DELAY_CLKS == 1) begin
            acc_rd_s    = i_cmd_rd_wr_n;
            acc_idx_s   = i_cmd_byte_addr[CMD_ADDR_BITS-1:2];
            acc_wdata_s = i_cmd_wdata;
            fire_s      = (state_q == ST_IDLE) && i_cmd_sel;
        end else begin
            acc_rd_s    = rd_q;
            acc_idx_s   = idx_q;
            acc_wdata_s = wdata_q;
            fire_s      = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
        end
        wr_en_s = fire_s && !acc_rd_s;
    end

    // One-hot decode of the RW control registers and their read mux.
    always_comb begin
        rw_hit_s  = {NUM_RW_REGS{1'b0}};
        rw_data_s = 32'h0000_0000;
        for (int k = 0; k < NUM_RW_REGS; k++) begin
            rw_hit_s[k] = (acc_idx_s == IDX_W'(k));
            rw_data_s   = rw_data_s | (regs_q[k] & {32{rw_hit_s[k]}});
        end
    end

    // Full read mux over the register map; anything not listed is unmapped.
    always_comb begin
        mapped_s = 1'b1;
        rd_val_s = 32'hDEAD_BEEF;
        if (|rw_hit_s) begin
            rd_val_s = rw_data_s;
        end else if (acc_idx_s == STATUS_IDX) begin
            rd_val_s = i_status;
        end else if (acc_idx_s == STICKY_IDX) begin
            rd_val_s = sticky_q;
        end else if (acc_idx_s == ID_IDX) begin
            rd_val_s = BLOCK_ID;
        end
`ifdef CMD_SLAVE_ERRCNT_EN
        else if (acc_idx_s == ERRCNT_IDX) begin
            rd_val_s = {16'h0000, errcnt_q};
        end
`endif
        else begin
            rd_val_s = 32'hDEAD_BEEF;
            mapped_s = 1'b0;
        end
    end

    // STICKY next state: events set, a STICKY write clears, set wins a tie.
    always_comb begin
        if (wr_en_s && (acc_idx_s == STICKY_IDX)) begin
            sticky_clr_s = acc_wdata_s;
        end else begin
            sticky_clr_s = 32'h0000_0000;
        end
        sticky_d = (sticky_q & ~sticky_clr_s) | i_event;
    end

    // Access FSM with registered ack and read data.
    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            rd_q    <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            wdata_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            ack_q <= fire_s;
            if (fire_s && acc_rd_s) begin
                rdata_q <= rd_val_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_sel) begin
                        rd_q    <= i_cmd_rd_wr_n;
                        idx_q   <= i_cmd_byte_addr[CMD_ADDR_BITS-1:2];
                        wdata_q <= i_cmd_wdata;
                        cnt_q   <= 5'd1;
                        if (ACK_DELAY_CLKS == 1) begin
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Register bank: RW writes land on the ack-asserting edge; STICKY every edge.
    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                regs_q[k] <= 32'h0000_0000;
            end
            sticky_q <= 32'h0000_0000;
        end else begin
            sticky_q <= sticky_d;
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                if (wr_en_s && rw_hit_s[k]) begin
                    regs_q[k] <= acc_wdata_s;
                end
            end
        end
    end

`ifdef CMD_SLAVE_ERRCNT_EN
    // Saturating count of unmapped accesses; a write to its own word clears it.
    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            errcnt_q <= 16'h0000;
        end else if (wr_en_s && (acc_idx_s == ERRCNT_IDX)) begin
            errcnt_q <= 16'h0000;
        end else if (fire_s && !mapped_s && (errcnt_q != 16'hFFFF)) begin
            errcnt_q <= errcnt_q + 16'h0001;
        end
    end
`endif

    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_ctrl_out
        assign o_ctrl_regs[32*g +: 32] = regs_q[g];
    end

    assign o_cmd_ack   = ack_q;
    assign o_cmd_rdata = rdata_q;

endmodule

// File: tb/tb_cmd_slave_regbank.sv
// Bench for cmd_slave_regbank: three instances (ack delays 1, 4 and 3) share
// one stimulus stream; a timeline model predicts ack, read data and control
// registers of each, checked every falling edge, plus literal expectations.
module tb_cmd_slave_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rd;
    logic [23:0] addr;
    logic [31:0] wd;
    logic [31:0] status;
    logic [31:0] event_v;
    logic        chk_en;

    logic [2:0]        ack_w;
    logic [2:0][31:0]  rdata_w;
    logic [2:0][255:0] ctrl_w;

    int n_pass  = 0;
    int n_total = 0;
    int n_ack;

    always #5 clk = ~clk;

    cmd_slave_regbank #(.CMD_ADDR_BITS(24), .NUM_RW_REGS(8), .ACK_DELAY_CLKS(1),
                        .BLOCK_ID(32'hB10C_0001)) u_d1 (
        .i_sysclk(clk), .i_arst(rst), .i_cmd_sel(sel), .i_cmd_rd_wr_n(rd),
        .i_cmd_byte_addr(addr), .i_cmd_wdata(wd), .o_cmd_ack(ack_w[0]),
        .o_cmd_rdata(rdata_w[0]), .o_ctrl_regs(ctrl_w[0]), .i_status(status),
        .i_event(event_v));

    cmd_slave_regbank #(.CMD_ADDR_BITS(24), .NUM_RW_REGS(8), .ACK_DELAY_CLKS(4),
                        .BLOCK_ID(32'hB10C_0004)) u_d4 (
        .i_sysclk(clk), .i_arst(rst), .i_cmd_sel(sel), .i_cmd_rd_wr_n(rd),
        .i_cmd_byte_addr(addr), .i_cmd_wdata(wd), .o_cmd_ack(ack_w[1]),
        .o_cmd_rdata(rdata_w[1]), .o_ctrl_regs(ctrl_w[1]), .i_status(status),
        .i_event(event_v));

    cmd_slave_regbank #(.CMD_ADDR_BITS(24), .NUM_RW_REGS(8), .ACK_DELAY_CLKS(3),
                        .BLOCK_ID(32'hB10C_0003)) u_d3 (
        .i_sysclk(clk), .i_arst(rst), .i_cmd_sel(sel), .i_cmd_rd_wr_n(rd),
        .i_cmd_byte_addr(addr), .i_cmd_wdata(wd), .o_cmd_ack(ack_w[2]),
        .o_cmd_rdata(rdata_w[2]), .o_ctrl_regs(ctrl_w[2]), .i_status(status),
        .i_event(event_v));

    // ---------------- model ----------------
    bit          m_busy [3];
    int          m_t    [3];
    bit          m_rd   [3];
    logic [31:0] m_addr [3];
    logic [31:0] m_wd   [3];
    logic [31:0] m_regs [3][8];
    logic [31:0] m_sticky [3];
    int          m_err  [3];
    logic        exp_ack   [3];
    logic [31:0] exp_rdata [3];
    bit          mf;
    int          mw;
    logic [31:0] mclr;

    function automatic int dly_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] id_of(input int i);
        return 32'hB10C_0000 + 32'(dly_of(i));
    endfunction

    function automatic bit m_mapped(input int w);
`ifdef CMD_SLAVE_ERRCNT_EN
        return w < 12;
`else
        return w < 11;
`endif
    endfunction

    function automatic logic [31:0] m_read(input int i, input int w);
        if (w < 8)   return m_regs[i][w];
        if (w == 8)  return status;
        if (w == 9)  return m_sticky[i];
        if (w == 10) return id_of(i);
`ifdef CMD_SLAVE_ERRCNT_EN
        if (w == 11) return 32'(m_err[i]);
`endif
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [255:0] m_flat(input int i);
        logic [255:0] f;
        for (int k = 0; k < 8; k++) f[32*k +: 32] = m_regs[i][k];
        return f;
    endfunction

    // Timeline model: a select taken at edge E completes at edge E+D-1 and
    // the slave is deaf to selects until edge E+D has passed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 1'b0; m_t[i] = 0; m_sticky[i] = 32'h0; m_err[i] = 0;
                exp_ack[i] = 1'b0; exp_rdata[i] = 32'h0;
                for (int k = 0; k < 8; k++) m_regs[i][k] = 32'h0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                mf = 1'b0;
                mclr = 32'h0;
                if (m_busy[i]) begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == dly_of(i) - 1) mf = 1'b1;
                    if (m_t[i] == dly_of(i)) m_busy[i] = 1'b0;
                end else if (sel) begin
                    m_busy[i] = 1'b1; m_t[i] = 0; m_rd[i] = rd;
                    m_addr[i] = {8'h00, addr}; m_wd[i] = wd;
                    if (dly_of(i) == 1) mf = 1'b1;
                end
                if (mf) begin
                    mw = int'(m_addr[i] >> 2);
                    if (m_rd[i]) begin
                        exp_rdata[i] = m_read(i, mw);
                    end else if (mw < 8) begin
                        m_regs[i][mw] = m_wd[i];
                    end else if (mw == 9) begin
                        mclr = m_wd[i];
                    end
`ifdef CMD_SLAVE_ERRCNT_EN
                    else if (mw == 11) begin
                        m_err[i] = 0;
                    end
`endif
                    if (!m_mapped(mw) && m_err[i] < 65535) m_err[i] = m_err[i] + 1;
                end
                m_sticky[i] = (m_sticky[i] & ~mclr) | event_v;
                exp_ack[i]  = mf;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Compare every instance against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk1($sformatf("mdl_ack_d%0d", dly_of(i)), ack_w[i], exp_ack[i]);
                chk32($sformatf("mdl_rdata_d%0d", dly_of(i)), rdata_w[i], exp_rdata[i]);
                chk256($sformatf("mdl_ctrl_d%0d", dly_of(i)), ctrl_w[i], m_flat(i));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input logic r, input logic [23:0] a, input logic [31:0] d);
        sel = 1'b1; rd = r; addr = a; wd = d;
        tick();
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; rd = 1'b0; addr = 24'h0; wd = 32'h0;
        status = 32'hA5A5_0F0F; event_v = 32'h0; chk_en = 1'b0; n_ack = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk1("rst_ack", ack_w[0], 1'b0);
        chk32("rst_rdata", rdata_w[0], 32'h0);
        chk256("rst_ctrl", ctrl_w[2], 256'h0);
        rst = 1'b0;

        // Write then read back word 1 right after reset release.
        issue(1'b0, 24'h000004, 32'h1234_5678);
        chk1("wr_ack_d1", ack_w[0], 1'b1);
        chk32("ctrl1_d1", ctrl_w[0][63:32], 32'h1234_5678);
        chk1("wr_ack_d4_early", ack_w[1], 1'b0);
        idle(6);
        chk32("ctrl1_d4", ctrl_w[1][63:32], 32'h1234_5678);
        issue(1'b1, 24'h000004, 32'h0);
        chk1("rd_ack_d1", ack_w[0], 1'b1);
        chk32("rd1_d1", rdata_w[0], 32'h1234_5678);
        idle(6);

        // Last RW word, ignored writes to STATUS/ID, read STATUS/ID/word 7.
        issue(1'b0, 24'h00001C, 32'hA5A5_0001); idle(6);
        issue(1'b0, 24'h000020, 32'hFFFF_FFFF); idle(6);
        issue(1'b0, 24'h000028, 32'h1111_1111); idle(6);
        status = 32'h0F0F_3C3C;
        issue(1'b1, 24'h000020, 32'h0);
        chk32("status_rd", rdata_w[0], 32'h0F0F_3C3C);
        idle(6);
        issue(1'b1, 24'h000028, 32'h0);
        chk32("id_rd_d1", rdata_w[0], 32'hB10C_0001);
        idle(6);
        chk32("id_rd_d3", rdata_w[2], 32'hB10C_0003);
        issue(1'b1, 24'h00001F, 32'h0);
        chk32("rd7_d1", rdata_w[0], 32'hA5A5_0001);
        idle(6);

        // Delay 4: second select two cycles later is ignored.
        issue(1'b1, 24'h000004, 32'h0);
        chk1("d4_ack_e0", ack_w[1], 1'b0);
        tick();
        chk1("d4_ack_e1", ack_w[1], 1'b0);
        sel = 1'b1; rd = 1'b1; addr = 24'h00001C;
        tick();
        sel = 1'b0;
        chk1("d4_ack_e2", ack_w[1], 1'b0);
        tick();
        chk1("d4_ack_e3", ack_w[1], 1'b1);
        chk32("d4_rdata", rdata_w[1], 32'h1234_5678);
        repeat (8) begin
            tick();
            n_ack = n_ack + int'(ack_w[1]);
        end
        chk32("d4_second_ack", 32'(n_ack), 32'h0);

        // STICKY: set bits 0 and 2, clear bit 0 while its event repeats.
        event_v = 32'h0000_0005;
        tick();
        event_v = 32'h0000_0001;
        issue(1'b0, 24'h000024, 32'h0000_0001);
        event_v = 32'h0;
        idle(6);
        issue(1'b1, 24'h000024, 32'h0);
        chk32("sticky_d1", rdata_w[0], 32'h0000_0005);
        chk32("mdl_sticky_pin", exp_rdata[0], 32'h0000_0005);
        idle(6);
        chk32("sticky_d4", rdata_w[1], 32'h0000_0004);

        // Unmapped read and the error-count word.
        issue(1'b1, 24'h000040, 32'h0);
        chk32("unmapped_rd", rdata_w[0], 32'hDEAD_BEEF);
        idle(6);
        issue(1'b1, 24'h00002C, 32'h0);
`ifdef CMD_SLAVE_ERRCNT_EN
        chk32("errcnt_one", rdata_w[0], 32'h0000_0001);
        idle(6);
        issue(1'b0, 24'h00002C, 32'h0);
        idle(6);
        issue(1'b1, 24'h00002C, 32'h0);
        chk32("errcnt_clr", rdata_w[0], 32'h0000_0000);
`else
        chk32("errcnt_absent", rdata_w[0], 32'hDEAD_BEEF);
`endif
        idle(6);

        // Reset in the middle of an access aborts it.
        issue(1'b0, 24'h000000, 32'hFFFF_FFFF);
        idle(6);
        chk32("reg0_d3", ctrl_w[2][31:0], 32'hFFFF_FFFF);
        issue(1'b0, 24'h000004, 32'h0000_0055);
        tick();
        #1 rst = 1'b1;
        #1;
        chk1("abort_ack_d3", ack_w[2], 1'b0);
        chk256("abort_ctrl_d3", ctrl_w[2], 256'h0);
        tick();
        chk1("abort_ack_d3_late", ack_w[2], 1'b0);
        rst = 1'b0; sel = 1'b1; rd = 1'b1; addr = 24'h000000;
        tick();
        sel = 1'b0;
        chk1("first_req_ack_d1", ack_w[0], 1'b1);
        chk32("rd0_d1", rdata_w[0], 32'h0);
        chk1("no_stale_ack_d3", ack_w[2], 1'b0);
        idle(6);
        chk32("rd0_d3", rdata_w[2], 32'h0);
        chk256("ctrl_d4_after", ctrl_w[1], 256'h0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
